fc_layer_engine: RTL and testbench

Fully-connected layer engine for the card-classifier CNN. It reads an int8 activation vector and an int8 row-major weight matrix (plus per-output int8 bias) from the layer memories, computes one multiply-accumulate per cycle, requantizes, and writes int8 outputs to the output buffer. It runs on a start/done handshake and sits directly downstream of the CNN memory block as its layer-3/layer-4 consumer; the final layer's argmax gives the detected card.

---
 rtl/fc_layer_engine_pkg.sv | 11 +
 rtl/fc_layer_engine_if.sv | 12 +
 rtl/fc_layer_engine_requant.sv | 17 +
 rtl/fc_layer_engine.sv | 91 +++++++++
 tb/tb_fc_layer_engine.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fc_layer_engine_pkg.sv
// fc_layer_engine_pkg: shared types, FSM states and int8 limits for the FC layer engine
package fc_layer_engine_pkg;
  typedef logic signed [7:0] int8_t;
  typedef logic signed [15:0] prod_t;
  typedef logic signed [31:0] acc_t;
  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_WRITE, S_DONE} fc_state_e;
  localparam int8_t INT8_MAX = 8'sh7f;
  localparam int8_t INT8_MIN = 8'sh80;
  localparam acc_t ACC_MAX = 32'sd127;
  localparam acc_t ACC_MIN = -32'sd128;
endpackage

// File: rtl/fc_layer_engine_if.sv
// fc_layer_engine_if: start/done handshake, memory read ports, output write port and argmax result
interface fc_layer_engine_if #(parameter int ADDR_W = 18);
  import fc_layer_engine_pkg::*;
  logic start, relu_en, busy, done, out_we;
  logic [ADDR_W-1:0] in_addr, w_addr, out_addr;
  int8_t in_data, w_data, out_data, max_val;
  logic [6:0] max_idx;
  modport master (input start, relu_en, in_data, w_data,
                  output busy, done, in_addr, w_addr, out_we, out_addr, out_data, max_idx, max_val);
  modport slave (output start, relu_en, in_data, w_data,
                 input busy, done, in_addr, w_addr, out_we, out_addr, out_data, max_idx, max_val);
endinterface

// File: rtl/fc_layer_engine_requant.sv
// fc_layer_engine_requant: rounding arithmetic right shift, int8 saturation and optional ReLU
module fc_layer_engine_requant import fc_layer_engine_pkg::*; #(
  parameter int SHIFT = 7
) (
  input  acc_t  acc,
  input  logic  relu_en,
  output int8_t r
);
  localparam acc_t HALF = acc_t'(1) <<< (SHIFT - 1);
  acc_t sh;
  int8_t sat;
  always_comb begin
    sh = (acc + HALF) >>> SHIFT;
    sat = sh > ACC_MAX ? INT8_MAX : sh < ACC_MIN ? INT8_MIN : sh[7:0];
    r = relu_en && sat[7] ? '0 : sat;
  end
endmodule

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: int8 fully-connected layer, one MAC per cycle, requantized int8 outputs.
// Define FC_ARGMAX_EN to track the argmax of the written outputs.
module fc_layer_engine import fc_layer_engine_pkg::*; #(
  parameter int IN_LEN = 200,
  parameter int OUT_LEN = 53,
  parameter int ADDR_W = 18,
  parameter int SHIFT = 7
) (
  input logic clk,
  input logic reset,
  fc_layer_engine_if.master bus
);
  localparam logic [ADDR_W-1:0] BIAS_BASE = ADDR_W'(OUT_LEN * IN_LEN);
  localparam logic [ADDR_W-1:0] IN_STEP = ADDR_W'(IN_LEN);
  localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(IN_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_O = ADDR_W'(OUT_LEN - 1);
  fc_state_e state, state_n;
  logic [ADDR_W-1:0] i, i_n, o, o_n, row, row_n, in_addr_q, in_addr_n, w_addr_q, w_addr_n;
  logic relu_q, bias_v, mac_v, we, go;
  acc_t acc;
  prod_t prod;
  int8_t r;
  assign go = state == S_IDLE && bus.start;
  assign we = state == S_WRITE;
  assign prod = bus.in_data * bus.w_data;
  // addresses are computed for the state being entered so they can be registered
  always_comb begin
    state_n = state == S_IDLE ? (bus.start ? S_BIAS : S_IDLE) :
              state == S_BIAS ? S_MAC :
              state == S_MAC ? (i == LAST_I ? S_DRAIN : S_MAC) :
              state == S_DRAIN ? S_WRITE :
              state == S_WRITE ? (o == LAST_O ? S_DONE : S_BIAS) : S_IDLE;
    i_n = state == S_MAC ? i + ADDR_W'(1) : '0;
    o_n = we ? o + ADDR_W'(1) : state == S_IDLE ? '0 : o;
    row_n = we ? row + IN_STEP : state == S_IDLE ? '0 : row;
    in_addr_n = state_n == S_MAC ? i_n : '0;
    w_addr_n = state_n == S_BIAS ? BIAS_BASE + o_n : state_n == S_MAC ? row_n + i_n : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      i <= '0;
      o <= '0;
      row <= '0;
      in_addr_q <= '0;
      w_addr_q <= '0;
      relu_q <= 1'b0;
      bias_v <= 1'b0;
      mac_v <= 1'b0;
      acc <= '0;
    end else begin
      state <= state_n;
      i <= i_n;
      o <= o_n;
      row <= row_n;
      in_addr_q <= in_addr_n;
      w_addr_q <= w_addr_n;
      relu_q <= go ? bus.relu_en : relu_q;
      bias_v <= state == S_BIAS;
      mac_v <= state == S_MAC;
      acc <= bias_v ? acc_t'(bus.w_data) <<< SHIFT : mac_v ? acc + acc_t'(prod) : acc;
    end
  end
  fc_layer_engine_requant #(.SHIFT(SHIFT)) u_requant (.acc(acc), .relu_en(relu_q), .r(r));
  assign bus.busy = state != S_IDLE && state != S_DONE;
  assign bus.done = state == S_DONE;
  assign bus.out_we = we;
  assign bus.out_addr = we ? o : '0;
  assign bus.out_data = we ? r : '0;
  assign bus.in_addr = in_addr_q;
  assign bus.w_addr = w_addr_q;
`ifdef FC_ARGMAX_EN
  logic [6:0] max_idx_q;
  int8_t max_val_q;
  // strict compare keeps the lowest index on ties
  always_ff @(posedge clk) begin
    if (reset || go) begin
      max_idx_q <= '0;
      max_val_q <= INT8_MIN;
    end else if (we && r > max_val_q) begin
      max_idx_q <= o[6:0];
      max_val_q <= r;
    end
  end
  assign bus.max_idx = max_idx_q;
  assign bus.max_val = max_val_q;
`else
  assign bus.max_idx = '0;
  assign bus.max_val = INT8_MIN;
`endif
endmodule

// File: tb/tb_fc_layer_engine.sv
// tb_fc_layer_engine: table-driven runs with a write scoreboard, plus start-while-busy and mid-run reset sequences
module tb_fc_layer_engine;
  import fc_layer_engine_pkg::*;
  localparam int IN_LEN = 4, OUT_LEN = 2, ADDR_W = 18, SHIFT = 2, NV = 7;
  typedef struct packed {
    logic [3:0][7:0] x;
    logic [7:0][7:0] w;
    logic [1:0][7:0] b;
    logic relu;
    logic [1:0][7:0] e;
    logic [6:0] mi;
    logic signed [7:0] mv;
  } vec_t;
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [7:0] d;
  } sb_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  fc_layer_engine_if #(.ADDR_W(ADDR_W)) bus();
  fc_layer_engine #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .ADDR_W(ADDR_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .bus(bus.master));
  int8_t xmem [4];
  int8_t wmem [16];
  always @(posedge clk) begin
    bus.in_data <= xmem[bus.in_addr[1:0]];
    bus.w_data <= wmem[bus.w_addr[3:0]];
  end
  vec_t tv [NV];
  sb_t sbq [$];
  int checks = 0, errors = 0, nwr = 0, ndone = 0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rep4(input logic [7:0] v);
    return {4{v}};
  endfunction

  function automatic vec_t mk(input logic [31:0] x, w0, w1, input logic [7:0] b0, b1, input logic relu,
                              input logic [7:0] e0, e1, input logic [6:0] mi, input logic [7:0] mv);
    vec_t v;
    v.x = x;
    v.w = {w1, w0};
    v.b = {b1, b0};
    v.relu = relu;
    v.e = {e1, e0};
    v.mi = mi;
    v.mv = mv;
    return v;
  endfunction

  // scoreboard monitor: every write must match the next expected {index, value}
  initial forever begin
    sb_t e;
    @(negedge clk);
    if (reset) prev_we = 1'b0;
    else begin
      if (bus.out_we) begin
        nwr++;
        chk("we_not_back_to_back", prev_we, 0);
        if (sbq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("out_addr", bus.out_addr, e.a);
          chk("out_data", bus.out_data, int8_t'(e.d));
        end
      end
      if (bus.done) ndone++;
      prev_we = bus.out_we;
    end
  end

  task automatic load(input int k);
    for (int i = 0; i < IN_LEN; i++) xmem[i] = tv[k].x[i];
    for (int j = 0; j < OUT_LEN * IN_LEN; j++) wmem[j] = tv[k].w[j];
    for (int o = 0; o < OUT_LEN; o++) wmem[OUT_LEN * IN_LEN + o] = tv[k].b[o];
    bus.relu_en = tv[k].relu;
  endtask

  task automatic run(input int k, input bit mid);
    int cyc;
    load(k);
    nwr = 0;
    ndone = 0;
    for (int o = 0; o < OUT_LEN; o++) sbq.push_back({ADDR_W'(o), tv[k].e[o]});
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.relu_en = ~tv[k].relu;
    cyc = 1;
    chk("busy_after_start", bus.busy, 1);
    while (!bus.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.start = mid && cyc == 4;
    end
    chk("done_cycle", cyc, 1 + OUT_LEN * (IN_LEN + 3));
    chk("busy_at_done", bus.busy, 0);
`ifdef FC_ARGMAX_EN
    chk("max_idx", bus.max_idx, tv[k].mi);
    chk("max_val", bus.max_val, tv[k].mv);
`else
    chk("max_idx", bus.max_idx, 0);
    chk("max_val", bus.max_val, -128);
`endif
    @(negedge clk);
    chk("write_count", nwr, OUT_LEN);
    chk("done_count", ndone, 1);
    chk("scoreboard_empty", sbq.size(), 0);
  endtask

  initial begin
    int cyc;
    tv[0] = mk(32'h04030201, rep4(8'h01), rep4(8'hf8), 8'h00, 8'h00, 1'b0, 8'h03, 8'hec, 7'd0, 8'h03);
    tv[1] = mk(32'h04030201, rep4(8'h01), rep4(8'hf8), 8'h05, 8'h00, 1'b1, 8'h08, 8'h00, 7'd0, 8'h08);
    tv[2] = mk(rep4(8'h7f), rep4(8'h7f), rep4(8'h7f), 8'h00, 8'h00, 1'b0, 8'h7f, 8'h7f, 7'd0, 8'h7f);
    tv[3] = mk(rep4(8'h7f), rep4(8'h80), rep4(8'h80), 8'h00, 8'h00, 1'b0, 8'h80, 8'h80, 7'd0, 8'h80);
    tv[4] = mk(32'h04030201, rep4(8'h02), rep4(8'h02), 8'h00, 8'h00, 1'b0, 8'h05, 8'h05, 7'd0, 8'h05);
    tv[5] = mk(32'h04030201, rep4(8'h01), rep4(8'h02), 8'h00, 8'h03, 1'b0, 8'h03, 8'h08, 7'd1, 8'h08);
    tv[6] = mk(rep4(8'hff), rep4(8'h01), 32'h00000003, 8'h00, 8'hff, 1'b0, 8'hff, 8'hfe, 7'd0, 8'hff);
    bus.start = 1'b0;
    bus.relu_en = 1'b0;
    for (int i = 0; i < 16; i++) wmem[i] = '0;
    for (int i = 0; i < 4; i++) xmem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out_we", bus.out_we, 0);
    chk("rst_in_addr", bus.in_addr, 0);
    chk("rst_w_addr", bus.w_addr, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_max_idx", bus.max_idx, 0);
    chk("rst_max_val", bus.max_val, -128);
    reset = 1'b0;
    for (int k = 0; k < NV; k++) run(k, 1'b0);
    run(0, 1'b1);
    run(0, 1'b0);
    // reset during the MAC phase of output 1: only output 0 may ever be written
    load(0);
    nwr = 0;
    ndone = 0;
    sbq.push_back({ADDR_W'(0), tv[0].e[0]});
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("busy_after_reset", bus.busy, 0);
    chk("we_after_reset", bus.out_we, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("reset_writes", nwr, 1);
    chk("reset_dones", ndone, 0);
    chk("reset_scoreboard", sbq.size(), 0);
    run(0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
